// File: rtl/pcie_ss_axis_ib2sb.sv
// pcie_ss_axis_ib2sb
// Converts a single-segment PCIe SS AXI-S TLP stream from in-band header
// format (header in the low 256 bits of the SOP beat) to side-band header
// format (header on tuser, payload realigned to bit 0).
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   in_t*_i / in_tready_o     in-band AXI-S input (SOP at bit 0 only)
//   out_t*_o / out_tready_i   side-band AXI-S output
//   out_tuser_vendor_o        {hdr, vendor}, non-zero on first beat only
//   out_tuser_hvalid_o        marks the first output beat of each packet
module pcie_ss_axis_ib2sb #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned HDR_WIDTH  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_tvalid_i,
  output logic                    in_tready_o,
  input  logic [DATA_WIDTH-1:0]   in_tdata_i,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep_i,
  input  logic                    in_tlast_i,
  input  logic                    in_tuser_vendor_i,
  output logic                    out_tvalid_o,
  input  logic                    out_tready_i,
  output logic [DATA_WIDTH-1:0]   out_tdata_o,
  output logic [DATA_WIDTH/8-1:0] out_tkeep_o,
  output logic                    out_tlast_o,
  output logic [HDR_WIDTH:0]      out_tuser_vendor_o,
  output logic                    out_tuser_hvalid_o
);

  localparam int unsigned HB  = HDR_WIDTH / 8;
  localparam int unsigned KW  = DATA_WIDTH / 8;
  localparam int unsigned SW  = DATA_WIDTH - HDR_WIDTH;
  localparam int unsigned SKW = KW - HB;

  localparam logic [1:0] ST_SOP   = 2'd0;
  localparam logic [1:0] ST_BODY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SW-1:0]         stash_q, stash_d;
  logic [SKW-1:0]        stash_keep_q, stash_keep_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic                  vnd_q, vnd_d;
  logic                  first_q, first_d;

  logic                  out_tvalid_q, out_tvalid_d;
  logic [DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic [KW-1:0]         out_tkeep_q, out_tkeep_d;
  logic                  out_tlast_q, out_tlast_d;
  logic [HDR_WIDTH:0]    out_tuser_q, out_tuser_d;
  logic                  out_hvalid_q, out_hvalid_d;

  logic adv;
  logic acc;
  logic upper_keep_zero;

  // Output register can take a new beat when empty or being drained
  assign adv         = !out_tvalid_q || out_tready_i;
  assign in_tready_o = adv && (state_q != ST_FLUSH);
  assign acc         = in_tvalid_i && in_tready_o;
  // Upper keep empty on a last BODY beat means no bytes spill into a FLUSH beat
  assign upper_keep_zero = (in_tkeep_i[KW-1:HB] == '0);

  // Next-state and output beat formation
  always_comb begin
    state_d      = state_q;
    stash_d      = stash_q;
    stash_keep_d = stash_keep_q;
    hdr_d        = hdr_q;
    vnd_d        = vnd_q;
    first_d      = first_q;
    out_tvalid_d = out_tvalid_q;
    out_tdata_d  = out_tdata_q;
    out_tkeep_d  = out_tkeep_q;
    out_tlast_d  = out_tlast_q;
    out_tuser_d  = out_tuser_q;
    out_hvalid_d = out_hvalid_q;

    // Beat drained with nothing new to emit: drop valid
    if (adv) begin
      out_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_SOP: begin
        if (acc) begin
          hdr_d        = in_tdata_i[HDR_WIDTH-1:0];
          vnd_d        = in_tuser_vendor_i;
          stash_d      = in_tdata_i[DATA_WIDTH-1:HDR_WIDTH];
          stash_keep_d = in_tkeep_i[KW-1:HB];
          if (in_tlast_i) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = {{HDR_WIDTH{1'b0}}, in_tdata_i[DATA_WIDTH-1:HDR_WIDTH]};
            out_tkeep_d  = {{HB{1'b0}}, in_tkeep_i[KW-1:HB]};
            out_tlast_d  = 1'b1;
            out_hvalid_d = 1'b1;
            out_tuser_d  = {in_tdata_i[HDR_WIDTH-1:0], in_tuser_vendor_i};
          end else begin
            first_d = 1'b1;
            state_d = ST_BODY;
          end
        end
      end

      ST_BODY: begin
        if (acc) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = {in_tdata_i[HDR_WIDTH-1:0], stash_q};
          out_tkeep_d  = {in_tkeep_i[HB-1:0], stash_keep_q};
          out_hvalid_d = first_q;
          out_tuser_d  = first_q ? {hdr_q, vnd_q} : '0;
          out_tlast_d  = 1'b0;
          first_d      = 1'b0;
          stash_d      = in_tdata_i[DATA_WIDTH-1:HDR_WIDTH];
          stash_keep_d = in_tkeep_i[KW-1:HB];
          if (in_tlast_i) begin
            if (upper_keep_zero) begin
              out_tlast_d = 1'b1;
              state_d     = ST_SOP;
            end else begin
              state_d = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        // Emit the leftover upper half of the last input beat
        if (adv) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = {{HDR_WIDTH{1'b0}}, stash_q};
          out_tkeep_d  = {{HB{1'b0}}, stash_keep_q};
          out_tlast_d  = 1'b1;
          out_hvalid_d = 1'b0;
          out_tuser_d  = '0;
          state_d      = ST_SOP;
        end
      end

      default: begin
        state_d = ST_SOP;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SOP;
      stash_q      <= '0;
      stash_keep_q <= '0;
      hdr_q        <= '0;
      vnd_q        <= 1'b0;
      first_q      <= 1'b0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= '0;
      out_hvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stash_q      <= stash_d;
      stash_keep_q <= stash_keep_d;
      hdr_q        <= hdr_d;
      vnd_q        <= vnd_d;
      first_q      <= first_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tlast_q  <= out_tlast_d;
      out_tuser_q  <= out_tuser_d;
      out_hvalid_q <= out_hvalid_d;
    end
  end

  assign out_tvalid_o       = out_tvalid_q;
  assign out_tdata_o        = out_tdata_q;
  assign out_tkeep_o        = out_tkeep_q;
  assign out_tlast_o        = out_tlast_q;
  assign out_tuser_vendor_o = out_tuser_q;
  assign out_tuser_hvalid_o = out_hvalid_q;

endmodule

// File: tb/tb_pcie_ss_axis_ib2sb.sv
// Testbench for pcie_ss_axis_ib2sb (DATA_WIDTH=512).
// Packets are described by header, vendor bit and payload length; the
// expected side-band beats are derived from the payload bytes and queued,
// then popped and compared as the DUT hands beats off.
module tb_pcie_ss_axis_ib2sb;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned HW = 256;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [HW:0]   tuser;
    logic          hvalid;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] in_tdata;
  logic [KW-1:0] in_tkeep;
  logic          in_tlast;
  logic          in_tuser_vendor;
  logic          out_tvalid;
  logic          out_tready;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic          out_tlast;
  logic [HW:0]   out_tuser_vendor;
  logic          out_tuser_hvalid;

  beat_t        sb_q[$];
  byte unsigned pl[0:1023];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           rand_bp = 1'b0;
  beat_t        mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pcie_ss_axis_ib2sb #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_tvalid_i        (in_tvalid),
    .in_tready_o        (in_tready),
    .in_tdata_i         (in_tdata),
    .in_tkeep_i         (in_tkeep),
    .in_tlast_i         (in_tlast),
    .in_tuser_vendor_i  (in_tuser_vendor),
    .out_tvalid_o       (out_tvalid),
    .out_tready_i       (out_tready),
    .out_tdata_o        (out_tdata),
    .out_tkeep_o        (out_tkeep),
    .out_tlast_o        (out_tlast),
    .out_tuser_vendor_o (out_tuser_vendor),
    .out_tuser_hvalid_o (out_tuser_hvalid)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) out_tready = ($urandom_range(15) != 0);
    #1;
  endtask

  function automatic logic [HW-1:0] rand_hdr();
    logic [HW-1:0] h;
    for (int i = 0; i < HW / 32; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  // Scoreboard check on every output handshake
  always @(negedge clk) begin
    if (!rst && out_tvalid && out_tready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_beat: observed out_tvalid=1 expected no beat");
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_tdata",  out_tdata,        mon_e.data);
        chk("out_tkeep",  out_tkeep,        mon_e.keep);
        chk("out_tlast",  out_tlast,        mon_e.last);
        chk("out_tuser",  out_tuser_vendor, mon_e.tuser);
        chk("out_hvalid", out_tuser_hvalid, mon_e.hvalid);
      end
    end
  end

  // Build one packet of p payload bytes, queue its expected side-band beats,
  // and drive its in-band beats. stall_at >= 0 holds out_tready low for five
  // cycles after that input beat is accepted.
  task automatic send_pkt(input logic [HW-1:0] hdr, input logic vnd, input int p, input int stall_at);
    int    nb_out, nb_in, cnt, base;
    beat_t e;
    for (int i = 0; i < p; i++) pl[i] = 8'($urandom);
    nb_out = (p == 0) ? 1 : (p + 63) / 64;
    for (int b = 0; b < nb_out; b++) begin
      e = '0;
      for (int i = 0; i < 64; i++) begin
        if (64 * b + i < p) begin
          e.data[8*i +: 8] = pl[64*b+i];
          e.keep[i]        = 1'b1;
        end
      end
      e.last = (b == nb_out - 1);
      if (b == 0) begin
        e.tuser  = {hdr, vnd};
        e.hvalid = 1'b1;
      end
      sb_q.push_back(e);
    end
    nb_in = (p <= 32) ? 1 : 1 + (p - 32 + 63) / 64;
    for (int j = 0; j < nb_in; j++) begin
      in_tdata = '0;
      in_tkeep = '0;
      if (j == 0) begin
        in_tdata[HW-1:0] = hdr;
        in_tkeep[31:0]   = '1;
        for (int i = 0; i < 32; i++) begin
          if (i < p) begin
            in_tdata[HW+8*i +: 8] = pl[i];
            in_tkeep[32+i]        = 1'b1;
          end
        end
      end else begin
        base = 32 + 64 * (j - 1);
        for (int i = 0; i < 64; i++) begin
          if (base + i < p) begin
            in_tdata[8*i +: 8] = pl[base+i];
            in_tkeep[i]        = 1'b1;
          end
        end
      end
      in_tlast        = (j == nb_in - 1);
      in_tuser_vendor = (j == 0) ? vnd : ~vnd;
      in_tvalid       = 1'b1;
      cnt = 0;
      while (!in_tready) begin
        tick();
        cnt++;
        if (cnt > 1000) begin
          $display("FAIL in_tready_timeout: observed in_tready=0 for %0d cycles expected 1", cnt);
          $fatal(1);
        end
      end
      tick();
      in_tvalid = 1'b0;
      if (j == stall_at) begin
        out_tready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
          chk("stall_tvalid", out_tvalid, 1'b1);
          chk("stall_tready", in_tready, 1'b0);
          chk("stall_tdata",  out_tdata, sb_q[0].data);
          chk("stall_tuser",  out_tuser_vendor, sb_q[0].tuser);
          tick();
        end
        out_tready = 1'b1;
        #1;
      end
    end
  endtask

  task automatic wait_empty();
    int cnt;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 2000) begin
      tick();
      cnt++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    in_tvalid       = 1'b0;
    in_tdata        = '0;
    in_tkeep        = '0;
    in_tlast        = 1'b0;
    in_tuser_vendor = 1'b0;
    out_tready      = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_tvalid", out_tvalid, 1'b0);
    chk("rst_tlast",  out_tlast, 1'b0);
    chk("rst_hvalid", out_tuser_hvalid, 1'b0);
    chk("rst_tdata",  out_tdata, '0);
    chk("rst_tkeep",  out_tkeep, '0);
    chk("rst_tuser",  out_tuser_vendor, '0);
    chk("rst_tready", in_tready, 1'b1);

    // Single-beat packet: 32 B payload
    send_pkt(rand_hdr(), 1'b1, 32, -1);
    wait_empty();

    // Header-only packet
    send_pkt(rand_hdr(), 1'b0, 0, -1);
    wait_empty();

    // 64 B payload, two input beats, no FLUSH
    send_pkt(rand_hdr(), 1'b1, 64, -1);
    chk("noflush_tready", in_tready, 1'b1);
    wait_empty();

    // 96 B payload, FLUSH needed: exactly one in_tready=0 cycle
    send_pkt(rand_hdr(), 1'b0, 96, -1);
    chk("flush_tready_lo", in_tready, 1'b0);
    tick();
    chk("flush_tready_hi", in_tready, 1'b1);
    wait_empty();

    // Back-to-back packets with no idle
    send_pkt(rand_hdr(), 1'b1, 100, -1);
    send_pkt(rand_hdr(), 1'b0, 20, -1);
    send_pkt(rand_hdr(), 1'b1, 160, -1);
    wait_empty();

    // Back-pressure mid-packet: outputs frozen for five cycles
    send_pkt(rand_hdr(), 1'b1, 200, 1);
    wait_empty();

    // Reset during BODY with a pending output beat
    in_tdata        = {256'hDEAD, rand_hdr()};
    in_tkeep        = '1;
    in_tlast        = 1'b0;
    in_tuser_vendor = 1'b1;
    in_tvalid       = 1'b1;
    tick();
    out_tready = 1'b0;
    in_tdata   = '1;
    tick();
    in_tvalid = 1'b0;
    chk("pre_rst_tvalid", out_tvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tvalid", out_tvalid, 1'b0);
    chk("mid_rst_tready", in_tready, 1'b1);
    out_tready = 1'b1;
    #1;
    send_pkt(rand_hdr(), 1'b1, 40, -1);
    wait_empty();

    // Random traffic with random output stalls
    rand_bp = 1'b1;
    for (int n = 0; n < 150; n++) begin
      send_pkt(rand_hdr(), 1'($urandom_range(1)), int'($urandom_range(300)), -1);
    end
    wait_empty();
    rand_bp    = 1'b0;
    out_tready = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
